// File: rtl/sle_bank_ctrl.sv
// rtl/sle_bank_ctrl.sv - init/arbitrate/verify sequencer for a WIDTH-bit SLE flop bank
// Optional SLE_BANK_RETRY_EN: reload a mismatching bank up to RETRY_MAX times before flagging err.
module sle_bank_ctrl #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0,
  parameter logic [WIDTH-1:0] INIT_VAL    = 8'hA5,
  parameter int               INIT_CYCLES = 2
`ifdef SLE_BANK_RETRY_EN
  , parameter int             RETRY_MAX   = 2
`endif
) (
  input  logic             clk,
  input  logic             ALn,
  input  logic             wr_req,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ack,
  input  logic             sl_req,
  input  logic [WIDTH-1:0] sl_value,
  output logic             sl_ack,
  input  logic             hold,
  input  logic             err_clr,
  input  logic [WIDTH-1:0] bank_q,
  output logic             sle_en,
  output logic             sle_sln,
  output logic [WIDTH-1:0] sle_sd,
  output logic [WIDTH-1:0] sle_d,
  output logic [WIDTH-1:0] sle_adn,
  output logic             sle_lat,
  output logic             busy,
  output logic             init_done,
  output logic             err
);
  localparam int CW = (INIT_CYCLES < 1) ? 1 : $clog2(INIT_CYCLES + 1);
  localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYCLES);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_LOAD, S_CHECK} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] exp_val, exp_n;
  logic             op_sd, op_sd_n;
  logic             en_n, sln_n, wr_ack_n, sl_ack_n, busy_n, init_done_n, err_n;
  logic [WIDTH-1:0] sd_n, d_n;
  logic             wr_ack_q, sl_ack_q;
  logic             mismatch, fail;

  assign sle_adn  = ~RESET_VAL;
  assign sle_lat  = 1'b0;
  assign mismatch = (state == S_CHECK) && (bank_q != exp_val);

`ifdef SLE_BANK_RETRY_EN
  localparam int RW = $clog2(RETRY_MAX + 1);
  logic [RW-1:0] retry_cnt, retry_n;
  logic          retry_now;

  assign retry_now = mismatch && (retry_cnt < RW'(RETRY_MAX));
  assign fail      = mismatch && !retry_now;
  // Whether a CHECK will retry is only known once bank_q is visible, so the ack is gated here.
  assign wr_ack    = wr_ack_q && !retry_now;
  assign sl_ack    = sl_ack_q && !retry_now;

  always_ff @(posedge clk or negedge ALn) begin
    if (!ALn) retry_cnt <= '0;
    else      retry_cnt <= retry_n;
  end
`else
  assign fail   = mismatch;
  assign wr_ack = wr_ack_q;
  assign sl_ack = sl_ack_q;
`endif

  always_ff @(posedge clk or negedge ALn) begin
    if (!ALn) begin
      state     <= S_INIT;
      cnt       <= '0;
      exp_val   <= '0;
      op_sd     <= 1'b0;
      sle_en    <= 1'b0;
      sle_sln   <= 1'b1;
      sle_sd    <= '0;
      sle_d     <= '0;
      wr_ack_q  <= 1'b0;
      sl_ack_q  <= 1'b0;
      busy      <= 1'b1;
      init_done <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      exp_val   <= exp_n;
      op_sd     <= op_sd_n;
      sle_en    <= en_n;
      sle_sln   <= sln_n;
      sle_sd    <= sd_n;
      sle_d     <= d_n;
      wr_ack_q  <= wr_ack_n;
      sl_ack_q  <= sl_ack_n;
      busy      <= busy_n;
      init_done <= init_done_n;
      err       <= err_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    exp_n       = exp_val;
    op_sd_n     = op_sd;
    init_done_n = init_done;
`ifdef SLE_BANK_RETRY_EN
    retry_n     = retry_cnt;
`endif
    case (state)
      S_INIT: begin
        if (cnt == INIT_LAST) begin
          state_n     = S_IDLE;
          init_done_n = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_IDLE: begin
        if (!hold && (sl_req || wr_req)) begin
          state_n = S_LOAD;
          op_sd_n = sl_req;
          exp_n   = sl_req ? sl_value : wr_data;
`ifdef SLE_BANK_RETRY_EN
          retry_n = '0;
`endif
        end
      end
      S_LOAD: state_n = S_CHECK;
      S_CHECK: begin
        state_n = S_IDLE;
`ifdef SLE_BANK_RETRY_EN
        if (retry_now) begin
          state_n = S_LOAD;
          retry_n = retry_cnt + RW'(1);
        end
`endif
      end
      default: state_n = S_INIT;
    endcase

    // Registered outputs are decoded from the state being entered so they hold for that whole state.
    en_n     = (state_n == S_INIT) || (state_n == S_LOAD);
    sln_n    = !((state_n == S_INIT) || ((state_n == S_LOAD) && op_sd_n));
    sd_n     = sle_sd;
    d_n      = sle_d;
    if (state_n == S_INIT) begin
      sd_n = INIT_VAL;
    end else if (state_n == S_LOAD) begin
      if (op_sd_n) sd_n = exp_n;
      else         d_n  = exp_n;
    end
    wr_ack_n = (state_n == S_CHECK) && !op_sd_n;
    sl_ack_n = (state_n == S_CHECK) && op_sd_n;
    busy_n   = (state_n != S_IDLE);
    err_n    = (err && !err_clr) || fail;
  end
endmodule

// File: tb/tb_sle_bank_ctrl.sv
// tb/tb_sle_bank_ctrl.sv - randomized self-checking bench for sle_bank_ctrl with an SLE bank model
module tb_sle_bank_ctrl;
`ifdef SLE_BANK_RETRY_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       ALn, wr_req, sl_req, hold, err_clr;
  logic [7:0] wr_data, sl_value, bank_q;
  logic       wr_ack, sl_ack, sle_en, sle_sln, sle_lat, busy, init_done, err;
  logic [7:0] sle_sd, sle_d, sle_adn;
  logic [7:0] bank, stuck_low;
  int         passed = 0, total = 0;

  always #5 clk = ~clk;

  sle_bank_ctrl dut (
    .clk(clk), .ALn(ALn), .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
    .sl_req(sl_req), .sl_value(sl_value), .sl_ack(sl_ack), .hold(hold), .err_clr(err_clr),
    .bank_q(bank_q), .sle_en(sle_en), .sle_sln(sle_sln), .sle_sd(sle_sd), .sle_d(sle_d),
    .sle_adn(sle_adn), .sle_lat(sle_lat), .busy(busy), .init_done(init_done), .err(err)
  );

  // SLE bank: async clear to 00, En-gated load of SD (SLn=0) or D (SLn=1), optional stuck-at-0 bits.
  always @(posedge clk or negedge ALn) begin
    if (!ALn)        bank <= 8'h00;
    else if (sle_en) bank <= sle_sln ? sle_d : sle_sd;
  end
  assign bank_q = bank & ~stuck_low;

  task automatic do_op(input bit is_sl, input logic [7:0] data, input int h,
                       output int ack_cyc, output int loads, output bit ok,
                       output logic [7:0] q, output logic e_ack);
    if (is_sl) begin sl_req = 1'b1; sl_value = data; end
    else       begin wr_req = 1'b1; wr_data  = data; end
    hold = (h > 0);
    ack_cyc = -1; loads = 0; ok = 1'b1; q = 8'hxx; e_ack = 1'bx;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == h) hold = 1'b0;
      if (sle_en) begin
        loads++;
        if (is_sl ? (sle_sln !== 1'b0 || sle_sd !== data) : (sle_sln !== 1'b1 || sle_d !== data)) ok = 1'b0;
      end
      if (wr_ack || sl_ack) begin
        ack_cyc = c; q = bank_q; e_ack = err;
        if (is_sl ? (!sl_ack || wr_ack) : (!wr_ack || sl_ack)) ok = 1'b0;
        wr_req = 1'b0; sl_req = 1'b0;
        break;
      end
    end
    hold = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    ALn = 1'b0; wr_req = 0; sl_req = 0; hold = 0; err_clr = 0; wr_data = 0; sl_value = 0; stuck_low = 0;
    repeat (2) @(negedge clk);
    total++; if ({busy, init_done, err, sle_en, sle_sln} !== 5'b10001) $display("FAIL reset_flags: got %b expected 10001", {busy, init_done, err, sle_en, sle_sln}); else passed++;
    total++; if ({wr_ack, sl_ack, sle_lat, sle_sd, sle_d} !== 19'd0) $display("FAIL reset_data: got ack=%b%b lat=%b sd=%h d=%h expected all 0", wr_ack, sl_ack, sle_lat, sle_sd, sle_d); else passed++;
    total++; if (sle_adn !== 8'hFF) $display("FAIL adn_const: got %h expected ff", sle_adn); else passed++;
    ALn = 1'b1;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      total++; if ({sle_en, sle_sln, sle_sd} !== {1'b1, 1'b0, 8'hA5}) $display("FAIL init_drive: got en=%b sln=%b sd=%h expected 1 0 a5", sle_en, sle_sln, sle_sd); else passed++;
    end
    total++; if (n !== 2) $display("FAIL init_cycles: got %0d expected 2", n); else passed++;
    total++; if ({init_done, err, sle_en, bank_q} !== {3'b100, 8'hA5}) $display("FAIL init_end: got done=%b err=%b en=%b q=%h expected 1 0 0 a5", init_done, err, sle_en, bank_q); else passed++;
  endtask

  task automatic test_write();
    int ac, ld; bit ok; logic [7:0] q; logic e;
    do_op(1'b0, 8'h3C, 0, ac, ld, ok, q, e);
    total++; if (ac !== 2) $display("FAIL write_latency: got %0d expected 2", ac); else passed++;
    total++; if ({ok, ld} !== {1'b1, 32'd1}) $display("FAIL write_load: got ok=%b loads=%0d expected 1 1", ok, ld); else passed++;
    total++; if (q !== 8'h3C) $display("FAIL write_bank: got %h expected 3c", q); else passed++;
    @(negedge clk);
    total++; if ({busy, err} !== 2'b00) $display("FAIL write_idle: got busy=%b err=%b expected 0 0", busy, err); else passed++;
  endtask

  task automatic test_priority();
    int sc = -1, wc = -1;
    logic [7:0] qs = 8'hxx, qw = 8'hxx;
    sl_req = 1'b1; sl_value = 8'h0F; wr_req = 1'b1; wr_data = 8'hF0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (sl_ack) begin sc = c; qs = bank_q; sl_req = 1'b0; end
      if (wr_ack) begin wc = c; qw = bank_q; wr_req = 1'b0; end
      if (sc > 0 && wc > 0) break;
    end
    sl_req = 1'b0; wr_req = 1'b0;
    total++; if (sc !== 2 || wc !== 5) $display("FAIL prio_order: got sl_ack@%0d wr_ack@%0d expected 2 and 5", sc, wc); else passed++;
    total++; if (qs !== 8'h0F || qw !== 8'hF0) $display("FAIL prio_bank: got %h then %h expected 0f then f0", qs, qw); else passed++;
    @(negedge clk);
  endtask

  task automatic test_hold();
    int bad = 0, ac = -1;
    hold = 1'b1; wr_req = 1'b1; wr_data = 8'h5A;
    repeat (5) begin
      @(negedge clk);
      if (busy || sle_en || wr_ack || sl_ack) bad++;
    end
    total++; if (bad !== 0) $display("FAIL hold_block: got %0d active cycles expected 0", bad); else passed++;
    hold = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (wr_ack) begin ac = c; wr_req = 1'b0; break; end
    end
    wr_req = 1'b0;
    total++; if (ac !== 2 || bank_q !== 8'h5A) $display("FAIL hold_release: got ack@%0d q=%h expected 2 5a", ac, bank_q); else passed++;
    @(negedge clk);
  endtask

  task automatic test_random();
    int ac, ld, h; bit ok, is_sl; logic [7:0] d, q; logic e;
    for (int i = 0; i < 24; i++) begin
      is_sl = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      h = $urandom_range(0, 3);
      do_op(is_sl, d, h, ac, ld, ok, q, e);
      total++; if (ac !== h + 2) $display("FAIL rnd_latency[%0d]: got %0d expected %0d", i, ac, h + 2); else passed++;
      total++; if ({ok, ld} !== {1'b1, 32'd1}) $display("FAIL rnd_load[%0d]: got ok=%b loads=%0d expected 1 1 (sl=%b d=%h)", i, ok, ld, is_sl, d); else passed++;
      total++; if (q !== d) $display("FAIL rnd_bank[%0d]: got %h expected %h", i, q, d); else passed++;
      @(negedge clk);
      total++; if (err !== 1'b0) $display("FAIL rnd_err[%0d]: got %b expected 0", i, err); else passed++;
    end
  endtask

  task automatic test_err();
    int ac, ld; bit ok; logic [7:0] q; logic e;
    stuck_low = 8'h01;
    do_op(1'b0, 8'h01, 0, ac, ld, ok, q, e);
    total++; if (ac !== 2 + 2 * EXTRA || ld !== 1 + EXTRA) $display("FAIL err_seq: got ack@%0d loads=%0d expected %0d %0d", ac, ld, 2 + 2 * EXTRA, 1 + EXTRA); else passed++;
    total++; if (q !== 8'h00 || e !== 1'b0) $display("FAIL err_ack: got q=%h err=%b expected 00 0", q, e); else passed++;
    @(negedge clk);
    total++; if (err !== 1'b1) $display("FAIL err_set: got %b expected 1", err); else passed++;
    err_clr = 1'b1;
    do_op(1'b1, 8'h03, 0, ac, ld, ok, q, e);
    total++; if (q !== 8'h02 || e !== 1'b0) $display("FAIL err_clr_mid: got q=%h err=%b expected 02 0", q, e); else passed++;
    @(negedge clk);
    total++; if (err !== 1'b1) $display("FAIL err_set_wins: got %b expected 1", err); else passed++;
    @(negedge clk);
    err_clr = 1'b0;
    total++; if (err !== 1'b0) $display("FAIL err_cleared: got %b expected 0", err); else passed++;
    stuck_low = 8'h00;
  endtask

  task automatic test_abort();
    int stale = 0;
    wr_req = 1'b1; wr_data = 8'h77;
    @(negedge clk);
    total++; if (sle_en !== 1'b1) $display("FAIL abort_inload: got en=%b expected 1", sle_en); else passed++;
    #2 ALn = 1'b0; wr_req = 1'b0;
    #1;
    total++; if ({wr_ack, sl_ack, busy, sle_en, init_done, bank_q} !== {5'b00100, 8'h00}) $display("FAIL abort_reset: got ack=%b%b busy=%b en=%b done=%b q=%h expected 00 1 0 0 00", wr_ack, sl_ack, busy, sle_en, init_done, bank_q); else passed++;
    @(negedge clk);
    ALn = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (wr_ack || sl_ack) stale++;
    end
    total++; if (stale !== 0) $display("FAIL abort_stale_ack: got %0d acks expected 0", stale); else passed++;
    total++; if ({init_done, busy, bank_q} !== {2'b10, 8'hA5}) $display("FAIL abort_reinit: got done=%b busy=%b q=%h expected 1 0 a5", init_done, busy, bank_q); else passed++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_priority();
    test_hold();
    test_random();
    test_err();
    test_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, %0d/%0d checks passed so far", passed, total);
    $fatal(1);
  end
endmodule
